// File: rtl/awb_gray_world_stats_pkg.sv
// Shared definitions for the gray-world AWB statistics engine.
// Default widths are the ones shared with white_balance; GAIN_ONE is unity gain
// at the default fractional precision.
package awb_gray_world_stats_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefGainWidth = 16;
  localparam int unsigned DefFracBits  = 8;
  localparam int unsigned DefSumWidth  = 32;

  localparam int unsigned GAIN_ONE = 1 << DefFracBits;

  typedef enum logic [1:0] {
    StIdle,
    StDivR,
    StDivB,
    StUpdate
  } awb_state_e;

endpackage

// File: rtl/awb_gray_world_stats_seq_divider.sv
// Unsigned restoring radix-2 divider, one quotient bit per cycle.
// Ports:
//   clk_i, rst_ni  - clock, async active-low reset
//   start_i        - clears the remainder; iterations run on the following Width edges
//   dividend_i     - dividend, must be held stable for the whole division
//   divisor_i      - divisor, must be held stable for the whole division
//   done_o         - high in the cycle whose closing edge performs the final iteration
//   quotient_o     - last completed quotient, held until the next completion
//   div_zero_o     - divisor was zero for the last completed division
// A start_i coinciding with done_o begins the next division back-to-back.
module awb_gray_world_stats_seq_divider #(
  parameter int unsigned Width = 40
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [Width-1:0] dividend_i,
  input  logic [Width-1:0] divisor_i,
  output logic             done_o,
  output logic [Width-1:0] quotient_o,
  output logic             div_zero_o
);

  localparam int unsigned CntW = $clog2(Width);

  logic [CntW-1:0]  cnt_q;
  logic             active_q;
  logic [Width-1:0] rem_q, rem_d;
  logic [Width-1:0] quo_q, quo_d;
  logic [Width-1:0] quotient_q;
  logic             zero_q;
  logic [CntW-1:0]  bit_idx;
  logic [Width:0]   shifted;
  logic [Width:0]   diff;

  // Dividend bits are consumed MSB first straight from the stable input.
  always_comb begin
    bit_idx = CntW'(Width - 1) - cnt_q;
    shifted = {rem_q, dividend_i[bit_idx]};
    diff    = shifted - {1'b0, divisor_i};
    rem_d   = diff[Width-1:0];
    quo_d   = {quo_q[Width-2:0], 1'b1};
    if (diff[Width]) begin
      rem_d = shifted[Width-1:0];
      quo_d = {quo_q[Width-2:0], 1'b0};
    end
  end

  assign done_o     = active_q && (cnt_q == CntW'(Width - 1));
  assign quotient_o = quotient_q;
  assign div_zero_o = zero_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      active_q   <= 1'b0;
      rem_q      <= '0;
      quo_q      <= '0;
      quotient_q <= '0;
      zero_q     <= 1'b0;
    end else begin
      if (active_q) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        cnt_q <= cnt_q + 1'b1;
        if (done_o) begin
          active_q   <= 1'b0;
          quotient_q <= quo_d;
          zero_q     <= (divisor_i == '0);
        end
      end
      // quo_q needs no clear: Width shifts fully replace its contents.
      if (start_i) begin
        rem_q    <= '0;
        cnt_q    <= '0;
        active_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/awb_gray_world_stats.sv
// Gray-world auto-white-balance statistics and gain engine.
// Accumulates per-channel sums over a frame, snapshots them on frame_end and
// computes gain_r = G/R and gain_b = G/B in unsigned fixed point with one
// time-shared sequential divider. gain_g is fixed at unity.
// Ports:
//   clk, rst_n               - clock, async active-low reset
//   enable                   - 0: frame_end is ignored and gains are held
//   frame_start, frame_end   - single-cycle frame delimiters
//   pixel_valid, pixel_r/g/b - pixel stream
//   gain_r/g/b               - registered gains (unity = 1 << FRAC_BITS)
//   gain_valid               - one-cycle pulse when the gains update
//   busy                     - gain computation in flight
module awb_gray_world_stats
  import awb_gray_world_stats_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned GAIN_WIDTH = DefGainWidth,
  parameter int unsigned FRAC_BITS  = DefFracBits,
  parameter int unsigned SUM_WIDTH  = DefSumWidth
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  frame_start,
  input  logic                  frame_end,
  input  logic                  pixel_valid,
  input  logic [DATA_WIDTH-1:0] pixel_r,
  input  logic [DATA_WIDTH-1:0] pixel_g,
  input  logic [DATA_WIDTH-1:0] pixel_b,
  output logic [GAIN_WIDTH-1:0] gain_r,
  output logic [GAIN_WIDTH-1:0] gain_g,
  output logic [GAIN_WIDTH-1:0] gain_b,
  output logic                  gain_valid,
  output logic                  busy
);

  localparam int unsigned DivWidth = SUM_WIDTH + FRAC_BITS;
  localparam logic [GAIN_WIDTH-1:0] GainUnity = GAIN_WIDTH'(1 << FRAC_BITS);

  function automatic logic [SUM_WIDTH-1:0] sat_add(input logic [SUM_WIDTH-1:0]  a,
                                                   input logic [DATA_WIDTH-1:0] b);
    logic [SUM_WIDTH:0] s;
    s = {1'b0, a} + (SUM_WIDTH + 1)'(b);
    return s[SUM_WIDTH] ? '1 : s[SUM_WIDTH-1:0];
  endfunction

  function automatic logic [GAIN_WIDTH-1:0] to_gain(input logic                zero,
                                                    input logic [DivWidth-1:0] q);
    if (zero)                            return GainUnity;
    else if (q[DivWidth-1:GAIN_WIDTH] != '0) return '1;
    else                                 return q[GAIN_WIDTH-1:0];
  endfunction

  // Channel index 0 = R, 1 = G, 2 = B.
  logic [2:0][DATA_WIDTH-1:0] pix;
  logic [2:0][SUM_WIDTH-1:0]  acc_q, acc_d, sum, snap_q;
  awb_state_e                 state_q, state_d;
  logic                       accept, div_start, div_done, div_zero, load_gains;
  logic [DivWidth-1:0]        div_dividend, div_divisor, div_quotient;
  logic [GAIN_WIDTH-1:0]      gain_r_q, gain_b_q, gain_r_pend_q;
  logic                       gain_valid_q;

  assign pix    = {pixel_b, pixel_g, pixel_r};
  assign accept = frame_end && enable && (state_q == StIdle);

  // frame_end always restarts the frame empty; the same-cycle pixel only
  // reaches the snapshot. frame_start alone keeps its pixel as first sample.
  always_comb begin
    sum   = '0;
    acc_d = '0;
    for (int c = 0; c < 3; c++) begin
      sum[c] = sat_add(acc_q[c], pixel_valid ? pix[c] : '0);
      if (frame_end)        acc_d[c] = '0;
      else if (frame_start) acc_d[c] = pixel_valid ? SUM_WIDTH'(pix[c]) : '0;
      else                  acc_d[c] = sum[c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      snap_q <= '0;
    end else begin
      acc_q <= acc_d;
      if (accept) snap_q <= sum;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_start  = 1'b0;
    load_gains = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d   = StDivR;
          div_start = 1'b1;
        end
      end
      StDivR: begin
        if (div_done) begin
          state_d   = StDivB;
          div_start = 1'b1;
        end
      end
      StDivB: begin
        if (div_done) state_d = StUpdate;
      end
      StUpdate: begin
        load_gains = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  assign div_dividend = DivWidth'(snap_q[1]) << FRAC_BITS;
  assign div_divisor  = DivWidth'((state_q == StDivB) ? snap_q[2] : snap_q[0]);

  awb_gray_world_stats_seq_divider #(
    .Width (DivWidth)
  ) u_divider (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (div_start),
    .dividend_i (div_dividend),
    .divisor_i  (div_divisor),
    .done_o     (div_done),
    .quotient_o (div_quotient),
    .div_zero_o (div_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gain_r_pend_q <= GainUnity;
      gain_r_q      <= GainUnity;
      gain_b_q      <= GainUnity;
      gain_valid_q  <= 1'b0;
    end else begin
      // The divider still presents the R result until the B division completes.
      if (state_q == StDivB && div_done) gain_r_pend_q <= to_gain(div_zero, div_quotient);
      gain_valid_q <= load_gains;
      if (load_gains) begin
        gain_r_q <= gain_r_pend_q;
        gain_b_q <= to_gain(div_zero, div_quotient);
      end
    end
  end

  assign gain_r     = gain_r_q;
  assign gain_g     = GainUnity;
  assign gain_b     = gain_b_q;
  assign gain_valid = gain_valid_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_awb_gray_world_stats.sv
module tb_awb_gray_world_stats;
  import awb_gray_world_stats_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, enable, frame_start, frame_end, pixel_valid;
  logic [7:0]  pixel_r, pixel_g, pixel_b;
  logic [15:0] gain_r, gain_g, gain_b;
  logic        gain_valid, busy;

  always #5 clk = ~clk;

  awb_gray_world_stats dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .pixel_valid (pixel_valid),
    .pixel_r     (pixel_r),
    .pixel_g     (pixel_g),
    .pixel_b     (pixel_b),
    .gain_r      (gain_r),
    .gain_g      (gain_g),
    .gain_b      (gain_b),
    .gain_valid  (gain_valid),
    .busy        (busy)
  );

  typedef struct {
    string           name;
    int unsigned     npix;
    logic [3:0][7:0] r;
    logic [3:0][7:0] g;
    logic [3:0][7:0] b;
    logic [15:0]     exp_r;
    logic [15:0]     exp_b;
  } vec_t;

  vec_t        vecs[6];
  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned gv_count = 0;

  always @(posedge clk) if (gain_valid) gv_count <= gv_count + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    pixel_valid = 1'b1;
    pixel_r = r;
    pixel_g = g;
    pixel_b = b;
    tick();
    pixel_valid = 1'b0;
  endtask

  // First pixel rides on frame_start.
  task automatic drive_pixels(input vec_t v);
    for (int i = 0; i < int'(v.npix); i++) begin
      frame_start = (i == 0);
      pixel(v.r[i], v.g[i], v.b[i]);
    end
    frame_start = 1'b0;
  endtask

  task automatic pulse_frame_end();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
  endtask

  // Returns edges after the current point at which gain_valid is seen; 0 if none.
  task automatic wait_gain(output int lat);
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (gain_valid) begin
        lat = k;
        return;
      end
    end
  endtask

  int          lat;
  int unsigned gv0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"unity",  4, {4{8'd100}}, {4{8'd100}}, {4{8'd100}}, 16'd256,   16'd256};
    vecs[1] = '{"ratio",  4, {4{8'd50}},  {4{8'd100}}, {4{8'd200}}, 16'd512,   16'd128};
    vecs[2] = '{"r_zero", 4, {4{8'd0}},   {4{8'd80}},  {4{8'd80}},  16'd256,   16'd256};
    vecs[3] = '{"r_sat",  2, {8'd0, 8'd0, 8'd0, 8'd1}, {4{8'd255}}, {4{8'd255}},
                16'd65535, 16'd256};
    vecs[4] = '{"b_big",  2, {4{8'd200}}, {4{8'd100}}, {4{8'd25}},  16'd128,   16'd1024};
    vecs[5] = '{"trunc",  3, {4{8'd3}},   {4{8'd10}},  {4{8'd7}},   16'd853,   16'd365};

    rst_n = 1'b0; enable = 1'b1; frame_start = 1'b0; frame_end = 1'b0;
    pixel_valid = 1'b0; pixel_r = '0; pixel_g = '0; pixel_b = '0;
    repeat (3) tick();
    check("reset gain_r", gain_r, 64'(GAIN_ONE));
    check("reset gain_g", gain_g, 64'(GAIN_ONE));
    check("reset gain_b", gain_b, 64'(GAIN_ONE));
    check("reset gain_valid", gain_valid, 0);
    check("reset busy", busy, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      drive_pixels(vecs[i]);
      pulse_frame_end();
      check({vecs[i].name, " busy_rise"}, busy, 1);
      wait_gain(lat);
      check({vecs[i].name, " latency"}, 64'(lat), 81);
      check({vecs[i].name, " gain_r"}, gain_r, vecs[i].exp_r);
      check({vecs[i].name, " gain_g"}, gain_g, 256);
      check({vecs[i].name, " gain_b"}, gain_b, vecs[i].exp_b);
      check({vecs[i].name, " busy_fall"}, busy, 0);
      tick();
      check({vecs[i].name, " gv_pulse"}, gain_valid, 0);
    end

    // Second frame_end at T+10 is dropped but still clears the sums.
    gv0 = gv_count;
    drive_pixels(vecs[1]);
    pulse_frame_end();
    pixel(8'd9, 8'd9, 8'd9);
    pixel(8'd9, 8'd9, 8'd9);
    repeat (7) tick();
    pulse_frame_end();
    check("drop busy", busy, 1);
    pixel(8'd100, 8'd50, 8'd25);
    pixel(8'd100, 8'd50, 8'd25);
    wait_gain(lat);
    check("drop seen", 64'(lat > 0), 1);
    check("drop gain_r", gain_r, 512);
    check("drop gain_b", gain_b, 128);
    tick();
    check("drop one_pulse", 64'(gv_count - gv0), 1);
    repeat (3) tick();
    pulse_frame_end();
    wait_gain(lat);
    check("after_drop gain_r", gain_r, 128);
    check("after_drop gain_b", gain_b, 512);

    // frame_end with frame_start: pixel goes to snapshot, not the new frame.
    frame_start = 1'b1;
    pixel(8'd10, 8'd20, 8'd40);
    frame_end = 1'b1;
    pixel(8'd10, 8'd20, 8'd40);
    frame_start = 1'b0;
    frame_end = 1'b0;
    wait_gain(lat);
    check("both gain_r", gain_r, 512);
    check("both gain_b", gain_b, 128);
    tick();
    pixel(8'd40, 8'd20, 8'd10);
    pulse_frame_end();
    wait_gain(lat);
    check("both_next gain_r", gain_r, 128);
    check("both_next gain_b", gain_b, 512);

    // enable low: frame_end ignored, gains held.
    tick();
    enable = 1'b0;
    gv0 = gv_count;
    drive_pixels(vecs[0]);
    pulse_frame_end();
    check("dis busy", busy, 0);
    repeat (100) tick();
    check("dis no_gv", 64'(gv_count - gv0), 0);
    check("dis gain_r", gain_r, 128);
    check("dis gain_b", gain_b, 512);
    enable = 1'b1;

    // Reset mid-computation.
    drive_pixels(vecs[1]);
    pulse_frame_end();
    repeat (49) tick();
    check("pre_rst busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst gain_r", gain_r, 256);
    check("rst gain_b", gain_b, 256);
    check("rst busy", busy, 0);
    check("rst gain_valid", gain_valid, 0);
    tick();
    rst_n = 1'b1;
    gv0 = gv_count;
    repeat (120) tick();
    check("post_rst no_gv", 64'(gv_count - gv0), 0);
    check("post_rst busy", busy, 0);
    check("post_rst gain_r", gain_r, 256);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
